rnd_rb_wlock: RTL and testbench

Sequential, parametrised weighted round-robin arbiter with frame lock, used at the switch-fabric output stage to pick one of RR_WIDTH ingress ports. It registers a one-hot and binary grant, holds the grant until the winner's frame completes, and lets a winner keep the grant for up to its programmed weight in frames. It then rotates priority past the winner. Handoff to the next winner has no bubble cycle.

---
 rtl/rnd_rb_wlock_pkg.sv | 16 +
 rtl/rnd_rb_scal.sv | 34 +++
 rtl/rnd_rb_wlock.sv | 135 +++++++++++++
 tb/tb_rnd_rb_wlock.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rnd_rb_wlock_pkg.sv
// Shared definitions for the weighted round-robin frame-lock arbiter:
// state encoding and the modulo-N pointer increment.
package rnd_rb_wlock_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_LOCK = 1'b1;

  // Increment an index modulo n; n-1 wraps to 0 so non-power-of-two
  // widths never produce an out-of-range pointer.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rnd_rb_scal.sv
// Combinational rotating-priority arbiter. Searches rr_vec_in upward from
// rr_priority, wrapping at RR_WIDTH-1, and returns the first set bit as
// both a one-hot vector and a binary index.
module rnd_rb_scal #(
  parameter int RR_WIDTH    = 4,
  parameter int RR_WIDTH_L2 = $clog2(RR_WIDTH)
) (
  input  logic [RR_WIDTH-1:0]    rr_vec_in,
  input  logic [RR_WIDTH_L2-1:0] rr_priority,
  output logic [RR_WIDTH-1:0]    rr_vec_out,
  output logic [RR_WIDTH_L2-1:0] rr_bin_out
);

  logic found;
  int   idx;

  // Walk the requesters in priority order and latch onto the first one set
  always_comb begin
    rr_vec_out = '0;
    rr_bin_out = '0;
    found      = 1'b0;
    idx        = 0;
    for (int k = 0; k < RR_WIDTH; k++) begin
      idx = int'(rr_priority) + k;
      if (idx >= RR_WIDTH) idx = idx - RR_WIDTH;
      if (!found && rr_vec_in[idx]) begin
        found           = 1'b1;
        rr_vec_out[idx] = 1'b1;
        rr_bin_out      = RR_WIDTH_L2'(idx);
      end
    end
  end

endmodule

// File: rtl/rnd_rb_wlock.sv
// Weighted round-robin arbiter with frame lock. The grant is held until the
// winner's frame ends; a winner may keep the grant for up to its weight in
// frames, after which priority rotates past it. Handoff is bubble-free:
// the release cycle already re-arbitrates with the advanced pointer.
module rnd_rb_wlock
  import rnd_rb_wlock_pkg::*;
#(
  parameter int RR_WIDTH    = 4,
  parameter int RR_WIDTH_L2 = $clog2(RR_WIDTH),
  parameter int WEIGHT_W    = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [RR_WIDTH-1:0]          rr_req,
  input  logic [RR_WIDTH-1:0]          rr_last,
  input  logic                         rr_ack,
  input  logic [RR_WIDTH*WEIGHT_W-1:0] rr_weight,
  output logic [RR_WIDTH-1:0]          rr_gnt_vec,
  output logic [RR_WIDTH_L2-1:0]       rr_gnt_bin,
  output logic                         rr_gnt_vld,
  output logic                         rr_err
);

  state_t                 state_reg, state_next;
  logic [RR_WIDTH_L2-1:0] ptr_reg, ptr_next, ptr_inc;
  logic [WEIGHT_W-1:0]    credit_reg, credit_next;
  logic [RR_WIDTH-1:0]    gnt_vec_reg, gnt_vec_next;
  logic [RR_WIDTH_L2-1:0] gnt_bin_reg, gnt_bin_next;
  logic                   err_reg, err_next;

  logic [RR_WIDTH-1:0]    arb_vec;
  logic [RR_WIDTH_L2-1:0] arb_bin;
  logic [WEIGHT_W-1:0]    arb_credit;
  logic [WEIGHT_W-1:0]    weight_arr [RR_WIDTH];

  logic locked, any_req, frame_end, abort, keep, rel_grant;

  // Split the packed weight bus into one field per requester
  for (genvar gi = 0; gi < RR_WIDTH; gi++) begin : g_weight
    assign weight_arr[gi] = rr_weight[gi*WEIGHT_W +: WEIGHT_W];
  end

  // Frame-end, abort and release detection plus pointer advance
  always_comb begin
    locked    = (state_reg == ST_LOCK);
    any_req   = |rr_req;
    frame_end = locked && rr_ack && rr_last[gnt_bin_reg];
    abort     = locked && !rr_req[gnt_bin_reg] && !frame_end;
    keep      = frame_end && (credit_reg > WEIGHT_W'(1)) && rr_req[gnt_bin_reg];
    rel_grant = (frame_end && !keep) || abort;
    ptr_inc   = RR_WIDTH_L2'(wrap_inc(int'(gnt_bin_reg), RR_WIDTH));
    ptr_next  = rel_grant ? ptr_inc : ptr_reg;
  end

  // Arbitration runs on the pointer the next cycle will hold, so a release
  // and the following grant happen in the same cycle
  rnd_rb_scal #(
    .RR_WIDTH   (RR_WIDTH),
    .RR_WIDTH_L2(RR_WIDTH_L2)
  ) u_scal (
    .rr_vec_in  (rr_req),
    .rr_priority(ptr_next),
    .rr_vec_out (arb_vec),
    .rr_bin_out (arb_bin)
  );

  // Winner's weight, with a programmed 0 treated as one frame
  always_comb begin
    arb_credit = weight_arr[arb_bin];
    if (arb_credit == '0) arb_credit = WEIGHT_W'(1);
  end

  // State register and rotation pointer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Next-state: lock on any request, drop to idle when a release finds nobody
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (any_req) state_next = ST_LOCK;
      ST_LOCK: if (rel_grant && !any_req) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Grant, credit and error updates: load a new winner, burn a credit, or hold
  always_comb begin
    gnt_vec_next = gnt_vec_reg;
    gnt_bin_next = gnt_bin_reg;
    credit_next  = credit_reg;
    err_next     = err_reg | abort;
    if (!locked || rel_grant) begin
      if (any_req) begin
        gnt_vec_next = arb_vec;
        gnt_bin_next = arb_bin;
        credit_next  = arb_credit;
      end else begin
        gnt_vec_next = '0;
        gnt_bin_next = '0;
        credit_next  = '0;
      end
    end else if (keep) begin
      credit_next = credit_reg - WEIGHT_W'(1);
    end
  end

  // Grant, credit and sticky error registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt_vec_reg <= '0;
      gnt_bin_reg <= '0;
      credit_reg  <= '0;
      err_reg     <= 1'b0;
    end else begin
      gnt_vec_reg <= gnt_vec_next;
      gnt_bin_reg <= gnt_bin_next;
      credit_reg  <= credit_next;
      err_reg     <= err_next;
    end
  end

  assign rr_gnt_vec = gnt_vec_reg;
  assign rr_gnt_bin = gnt_bin_reg;
  assign rr_gnt_vld = (state_reg == ST_LOCK);
  assign rr_err     = err_reg;

endmodule

// File: tb/tb_rnd_rb_wlock.sv
// Bench for rnd_rb_wlock: a 4-requester and a 5-requester instance checked
// every cycle against a frame-level reference model, plus directed steps.
module tb_rnd_rb_wlock;

  logic        clk;
  logic        rstn;

  logic [3:0]  req4, last4, vec4;
  logic        ack4, vld4, err4;
  logic [15:0] weight4;
  logic [1:0]  bin4;

  logic [4:0]  req5, last5, vec5;
  logic        ack5, vld5, err5;
  logic [19:0] weight5;
  logic [2:0]  bin5;

  int checks = 0;
  int errors = 0;

  // Reference model state: granted index (-1 when idle), pointer, credit, error
  int m4_gnt, m4_ptr, m4_cred;
  bit m4_err;
  int m5_gnt, m5_ptr, m5_cred;
  bit m5_err;
  int wt4 [8];
  int wt5 [8];

  rnd_rb_wlock #(.RR_WIDTH(4), .WEIGHT_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .rr_req(req4), .rr_last(last4), .rr_ack(ack4),
    .rr_weight(weight4), .rr_gnt_vec(vec4), .rr_gnt_bin(bin4),
    .rr_gnt_vld(vld4), .rr_err(err4)
  );

  rnd_rb_wlock #(.RR_WIDTH(5), .WEIGHT_W(4)) dut5 (
    .clk(clk), .rstn(rstn), .rr_req(req5), .rr_last(last5), .rr_ack(ack5),
    .rr_weight(weight5), .rr_gnt_vec(vec5), .rr_gnt_bin(bin5),
    .rr_gnt_vld(vld5), .rr_err(err5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requester at or after ptr, scanning upward with wrap
  function automatic int pick(input logic [7:0] req, input int ptr, input int n);
    for (int k = 0; k < n; k++)
      if (req[(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  function automatic int eff_weight(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  // One clock of the arbiter's frame-level rules
  task automatic model_step(input int n, input logic [7:0] req, input logic [7:0] last,
                            input logic ack, input int wt [8],
                            inout int gnt, inout int ptr, inout int cred, inout bit err);
    bit rel;
    rel = 1'b0;
    if (gnt < 0) begin
      if (req != 0) begin
        gnt  = pick(req, ptr, n);
        cred = eff_weight(wt[gnt]);
      end
    end else begin
      if (ack && last[gnt]) begin
        if (cred > 1 && req[gnt]) cred = cred - 1;
        else rel = 1'b1;
      end else if (!req[gnt]) begin
        rel = 1'b1;
        err = 1'b1;
      end
      if (rel) begin
        ptr = (gnt + 1) % n;
        if (req != 0) begin
          gnt  = pick(req, ptr, n);
          cred = eff_weight(wt[gnt]);
        end else begin
          gnt  = -1;
          cred = 0;
        end
      end
    end
  endtask

  task automatic model_reset();
    m4_gnt = -1; m4_ptr = 0; m4_cred = 0; m4_err = 1'b0;
    m5_gnt = -1; m5_ptr = 0; m5_cred = 0; m5_err = 1'b0;
  endtask

  task automatic apply_weights();
    for (int i = 0; i < 4; i++) weight4[i*4 +: 4] = wt4[i][3:0];
    for (int i = 0; i < 5; i++) weight5[i*4 +: 4] = wt5[i][3:0];
  endtask

  task automatic check_outputs();
    check("vld4", {31'd0, vld4}, {31'd0, m4_gnt >= 0});
    check("vec4", {28'd0, vec4}, (m4_gnt >= 0) ? (32'd1 << m4_gnt) : 32'd0);
    if (m4_gnt >= 0) check("bin4", {30'd0, bin4}, m4_gnt);
    check("err4", {31'd0, err4}, {31'd0, m4_err});
    check("vld5", {31'd0, vld5}, {31'd0, m5_gnt >= 0});
    check("vec5", {27'd0, vec5}, (m5_gnt >= 0) ? (32'd1 << m5_gnt) : 32'd0);
    if (m5_gnt >= 0) check("bin5", {29'd0, bin5}, m5_gnt);
    check("err5", {31'd0, err5}, {31'd0, m5_err});
  endtask

  // Predict from the inputs now on the pins, clock once, compare after the edge
  task automatic tick();
    model_step(4, {4'd0, req4}, {4'd0, last4}, ack4, wt4, m4_gnt, m4_ptr, m4_cred, m4_err);
    model_step(5, {3'd0, req5}, {3'd0, last5}, ack5, wt5, m5_gnt, m5_ptr, m5_cred, m5_err);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Reset pulse between edges; all outputs must read zero while it is held
  task automatic do_reset();
    req4 = '0; last4 = '0; ack4 = 1'b0;
    req5 = '0; last5 = '0; ack5 = 1'b0;
    rstn = 1'b0;
    #2;
    model_reset();
    check_outputs();
    rstn = 1'b1;
  endtask

  int seq1 [5] = '{0, 1, 2, 3, 0};
  int seq2 [8] = '{1, 1, 1, 2, 1, 1, 1, 2};
  int seq4 [4] = '{0, 4, 0, 4};

  initial begin
    rstn = 1'b0;
    req4 = '0; last4 = '0; ack4 = 1'b0;
    req5 = '0; last5 = '0; ack5 = 1'b0;
    for (int i = 0; i < 8; i++) begin wt4[i] = 1; wt5[i] = 1; end
    apply_weights();
    model_reset();
    #12;
    check_outputs();
    check("reset_vec4", {28'd0, vec4}, 32'd0);
    check("reset_bin4", {30'd0, bin4}, 32'd0);
    rstn = 1'b1;

    // 1: four requesters, unit weights, one-beat frames
    tick();
    check("t1_idle_vld", {31'd0, vld4}, 32'd0);
    req4 = 4'b1111; last4 = 4'b1111; ack4 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t1_vld", {31'd0, vld4}, 32'd1);
      check($sformatf("t1_gnt%0d", k), {30'd0, bin4}, seq1[k]);
      $display("t1 step %0d gnt=%0d", k, bin4);
    end

    // 2: weight 3 on requester 1
    do_reset();
    wt4[1] = 3;
    apply_weights();
    req4 = 4'b0110; last4 = 4'b1111; ack4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("t2_gnt%0d", k), {30'd0, bin4}, seq2[k]);
      $display("t2 step %0d gnt=%0d", k, bin4);
    end

    // 3: lone requester re-wins with no gap
    do_reset();
    wt4[1] = 1;
    apply_weights();
    req4 = 4'b0100; last4 = 4'b1111; ack4 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_vld", {31'd0, vld4}, 32'd1);
      check("t3_gnt", {30'd0, bin4}, 32'd2);
      $display("t3 step %0d gnt=%0d vld=%0d", k, bin4, vld4);
    end

    // 4: five requesters, pointer wraps from 4 to 0
    do_reset();
    req5 = 5'b10001; last5 = 5'b11111; ack5 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t4_gnt%0d", k), {29'd0, bin5}, seq4[k]);
      $display("t4 step %0d gnt=%0d", k, bin5);
    end

    // 5: abort mid-frame sets the sticky error and hands off to requester 1
    do_reset();
    req4 = 4'b1000; last4 = 4'b0000; ack4 = 1'b0;
    tick();
    check("t5_gnt3", {30'd0, bin4}, 32'd3);
    tick();
    check("t5_noerr", {31'd0, err4}, 32'd0);
    req4 = 4'b0010;
    tick();
    check("t5_err", {31'd0, err4}, 32'd1);
    check("t5_gnt1", {30'd0, bin4}, 32'd1);
    $display("t5 abort err=%0d gnt=%0d", err4, bin4);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_sticky", {31'd0, err4}, 32'd1);
    end

    // 6: asynchronous reset during a 4-beat frame
    do_reset();
    req4 = 4'b0001; last4 = 4'b0000; ack4 = 1'b1;
    tick();
    check("t6_gnt0", {30'd0, bin4}, 32'd0);
    tick();
    tick();
    #3;
    rstn = 1'b0;
    #1;
    check("t6_async_vld", {31'd0, vld4}, 32'd0);
    check("t6_async_vec", {28'd0, vec4}, 32'd0);
    check("t6_async_bin", {30'd0, bin4}, 32'd0);
    check("t6_async_err", {31'd0, err4}, 32'd0);
    model_reset();
    req4 = 4'b0010; ack4 = 1'b0;
    rstn = 1'b1;
    tick();
    check("t6_gnt1", {30'd0, bin4}, 32'd1);
    check("t6_vld", {31'd0, vld4}, 32'd1);
    $display("t6 after reset gnt=%0d vld=%0d", bin4, vld4);

    // Random phase: random weights (including 0), sticky-ish requests
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wt4[i] = $urandom_range(0, 3);
      wt5[i] = $urandom_range(0, 3);
    end
    apply_weights();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0) req4 = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req5 = 5'($urandom_range(0, 31));
      last4 = 4'($urandom);
      last5 = 5'($urandom_range(0, 31));
      ack4  = 1'($urandom);
      ack5  = 1'($urandom);
      tick();
      $display("rnd %0d req4=%b gnt4=%0d vld4=%0d req5=%b gnt5=%0d vld5=%0d",
               c, req4, bin4, vld4, req5, bin5, vld5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
